// File: rtl/edge_detect_dly.sv
// Purpose : single-bit edge detector whose one-cycle detect pulse is carried down a fixed delay line.
// Latency : pulse leaves NUM_DLY cycles after the edge that registers the new level into a_q.
// Backpr. : none; free-running stream, every qualifying transition yields exactly one pulse.
//
// Ports:
//   clk            clock, all state updates on the rising edge
//   rst            asynchronous, active-high reset; clears input history and delay line
//   a_i            level input, already synchronous to clk (no synchroniser here)
//   edge_detect_o  delayed single-cycle edge pulse, driven straight from the last delay flop
//
// Parameters:
//   NUM_DLY    delay-line depth in cycles, 1..256
//   EDGE_TYPE  0 = rising, 1 = falling, 2 = both; any other value behaves as rising

module edge_detect_dly #(
  parameter int NUM_DLY   = 13,
  parameter int EDGE_TYPE = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic a_i,
  output logic edge_detect_o
);

  // Out-of-range depths are rejected at elaboration rather than silently clipped.
  generate
    if (NUM_DLY < 1 || NUM_DLY > 256) begin : g_bad_num_dly
      $error("edge_detect_dly: NUM_DLY=%0d outside 1..256", NUM_DLY);
    end
  endgenerate

  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_BOTH = 2;

  logic               a_q;
  logic               a_q2;
  logic               raw;
  logic [NUM_DLY-1:0] dly;

  // Two-deep input history. Reset leaves both low, so a level that is already
  // high when reset releases is seen as a fresh rising transition.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q  <= 1'b0;
      a_q2 <= 1'b0;
    end else begin
      a_q  <= a_i;
      a_q2 <= a_q;
    end
  end

  // Raw detect is purely combinational from the history; it is registered
  // immediately by the first delay stage.
  always_comb begin
    raw = 1'b0;
    case (EDGE_TYPE)
      EDGE_FALL: raw = ~a_q & a_q2;
      EDGE_BOTH: raw = a_q ^ a_q2;
      default:   raw = a_q & ~a_q2;   // EDGE_RISE and any unsupported selector
    endcase
  end

  // Pure shift register: several pulses may be in flight at once and keep
  // their exact spacing. Reset discards everything in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dly <= '0;
    end else begin
      dly[0] <= raw;
      for (int i = 1; i < NUM_DLY; i++) begin
        dly[i] <= dly[i-1];
      end
    end
  end

  assign edge_detect_o = dly[NUM_DLY-1];

  // Single-edge modes can never produce back-to-back pulses: a second
  // qualifying edge needs the level to go away and come back first.
  generate
    if (EDGE_TYPE != EDGE_BOTH) begin : g_single_edge_chk
      a_no_back_to_back : assert property (
        @(posedge clk) disable iff (rst) edge_detect_o |=> !edge_detect_o
      );
    end
  endgenerate

  // The selector constants above document the encoding; reference the rise
  // code so every localparam is used.
  generate
    if (EDGE_RISE != 0) begin : g_enc_chk
      $error("edge_detect_dly: rising-edge encoding must be 0");
    end
  endgenerate

endmodule

// File: tb/tb_edge_detect_dly.sv
// Table-driven bench for edge_detect_dly with four parameterisations sharing
// one input and reset:
//   bit0: NUM_DLY=13 rising   bit1: NUM_DLY=13 falling
//   bit2: NUM_DLY=4  both     bit3: NUM_DLY=1  falling
// Timing convention: a_i is changed 1 ns after posedge j ("driven at j"), is
// captured at posedge j+1, and the pulse occupies the cycle starting at
// posedge j+1+NUM_DLY. Outputs are sampled on the falling edge.

module tb_edge_detect_dly;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic a_i = 1'b0;
  logic o13r, o13f, o4b, o1f;
  logic [3:0] outs;

  always #5 clk = ~clk;

  edge_detect_dly #(.NUM_DLY(13), .EDGE_TYPE(0)) u13r (.clk(clk), .rst(rst), .a_i(a_i), .edge_detect_o(o13r));
  edge_detect_dly #(.NUM_DLY(13), .EDGE_TYPE(1)) u13f (.clk(clk), .rst(rst), .a_i(a_i), .edge_detect_o(o13f));
  edge_detect_dly #(.NUM_DLY(4),  .EDGE_TYPE(2)) u4b  (.clk(clk), .rst(rst), .a_i(a_i), .edge_detect_o(o4b));
  edge_detect_dly #(.NUM_DLY(1),  .EDGE_TYPE(1)) u1f  (.clk(clk), .rst(rst), .a_i(a_i), .edge_detect_o(o1f));

  assign outs = {o1f, o4b, o13f, o13r};

  typedef struct {
    logic       a;
    logic [3:0] exp;
  } vec_t;

  localparam int NVEC = 180;
  vec_t vt [NVEC];

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [3:0] exp);
    n_vec++;
    if (outs !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b (bits: 1f 4b 13f 13r)", name, outs, exp);
    end
  endtask

  // Hand-computed pulse cycles per instance for the table below.
  int p13r [8]  = '{16, 44, 124, 126, 128, 130, 132, 164};
  int p13f [8]  = '{17, 94, 125, 127, 129, 131, 133, 167};
  int p4b  [16] = '{7, 8, 35, 85, 115, 116, 117, 118, 119, 120, 121, 122, 123, 124, 155, 158};
  int p1f  [8]  = '{5, 82, 113, 115, 117, 119, 121, 155};

  initial begin
    // ---- table: stimulus ----
    for (int j = 0; j < NVEC; j++) begin
      vt[j].a   = 1'b0;
      vt[j].exp = 4'b0000;
    end
    vt[2].a = 1'b1;                                      // one-cycle input pulse
    for (int j = 30; j < 80; j++) vt[j].a = 1'b1;        // 50-cycle hold
    for (int i = 0; i < 10; i++) vt[110+i].a = (i % 2 == 0);  // toggle each cycle
    for (int j = 150; j < 153; j++) vt[j].a = 1'b1;      // 3 high, low at 153
    // ---- table: expected pulses ----
    foreach (p13r[i]) vt[p13r[i]].exp[0] = 1'b1;
    foreach (p13f[i]) vt[p13f[i]].exp[1] = 1'b1;
    foreach (p4b[i])  vt[p4b[i]].exp[2]  = 1'b1;
    foreach (p1f[i])  vt[p1f[i]].exp[3]  = 1'b1;

    // ---- reset for 3 cycles ----
    #2 rst = 1'b1;
    #1 check("async_reset_t0", 4'b0000);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("in_reset", 4'b0000);
    @(posedge clk);
    #1 rst = 1'b0;

    // ---- table-driven run ----
    for (int j = 0; j < NVEC; j++) begin
      @(posedge clk);
      #1 a_i = vt[j].a;
      @(negedge clk);
      check($sformatf("vec%0d", j), vt[j].exp);
    end

    // ---- async reset mid-cycle discards in-flight pulses ----
    @(posedge clk);
    #1 a_i = 1'b1;                 // rising edge driven at c0
    repeat (5) @(posedge clk);     // now in cycle c0+5: 4-deep both-edge pulse is high
    #2 check("pre_reset_pulse", 4'b0100);
    #1 begin
      rst = 1'b1;
      a_i = 1'b0;
    end
    #1 check("async_clear", 4'b0000);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check($sformatf("post_rst_quiet%0d", i), 4'b0000);
      @(posedge clk);
      #1;
    end

    // ---- input held high through reset release ----
    a_i = 1'b1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;                 // next posedge sees history low, a_i high
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      check($sformatf("rel_high%0d", i), {1'b0, (i == 5), 1'b0, (i == 14)});
      @(posedge clk);
      #1;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
